// File: rtl/hud_char_sequencer_if.sv
// Glyph ROM bus: registered address/select out, ROM word back one cycle later.
interface hud_char_sequencer_if;
  logic [18:0] char_read_address;
  logic [3:0]  char_idx;
  logic [4:0]  char_data_in;

  modport master (
    output char_read_address,
    output char_idx,
    input  char_data_in
  );

  modport slave (
    input  char_read_address,
    input  char_idx,
    output char_data_in
  );
endinterface

// File: rtl/hud_char_sequencer.sv
// HUD score/health glyph sequencer with double-dabble BCD shadow registers.
// Optional: HUD_LEADING_ZERO_BLANK_EN blanks leading zero score digits.
module hud_char_sequencer #(
  parameter int SCORE_X = 500,
  parameter int SCORE_Y = 10,
  parameter int HEART_X = 10,
  parameter int HEART_Y = 10
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic [13:0]                 score,
  input  logic [3:0]                  health,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  hud_char_sequencer_if.master        rom,
  output logic [4:0]                  hud_pixel,
  output logic                        hud_valid,
  output logic                        bcd_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [10:0] SX0 = 11'(SCORE_X);
  localparam logic [10:0] SX1 = 11'(SCORE_X + 119);
  localparam logic [10:0] SY0 = 11'(SCORE_Y);
  localparam logic [10:0] SY1 = 11'(SCORE_Y + 44);
  localparam logic [10:0] HX0 = 11'(HEART_X);
  localparam logic [10:0] HX1 = 11'(HEART_X + 149);
  localparam logic [10:0] HY0 = 11'(HEART_Y);
  localparam logic [10:0] HY1 = 11'(HEART_Y + 44);

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  logic [1:0]  state;
  logic [3:0]  iter;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  lat_health;
  logic [15:0] sh_digits;
  logic [3:0]  sh_health;

  always_comb begin
    bcd_adj = {adj3(bcd[15:12]), adj3(bcd[11:8]),
               adj3(bcd[7:4]), adj3(bcd[3:0])};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      iter       <= 4'd0;
      bin        <= 14'd0;
      bcd        <= 16'd0;
      lat_health <= 4'd0;
      sh_digits  <= 16'd0;
      sh_health  <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            bin        <= (score > 14'd9999) ? 14'd9999 : score;
            lat_health <= (health > 4'd10) ? 4'd10 : health;
            bcd        <= 16'd0;
            iter       <= 4'd0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'd13) state <= S_COMMIT;
        end
        S_COMMIT: begin
          sh_digits <= bcd;
          sh_health <= lat_health;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bcd_busy = (state != S_IDLE);

  logic [9:0] px;
  logic [9:0] py;
  logic       s0_v;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      px   <= 10'd0;
      py   <= 10'd0;
      s0_v <= 1'b0;
    end else begin
      px   <= DrawX;
      py   <= DrawY;
      s0_v <= 1'b1;
    end
  end

  logic [10:0] xs;
  logic [10:0] ys;
  logic        in_score;
  logic        in_heart;
  logic [10:0] off;
  logic [5:0]  row;
  logic [2:0]  k;
  logic [4:0]  col;
  logic [10:0] addr11;
  logic [3:0]  dsel;
  logic [3:0]  glyph_s;
  logic [3:0]  glyph_h;
  logic [4:0]  two_i;
  logic [4:0]  hh;
`ifdef HUD_LEADING_ZERO_BLANK_EN
  logic        lead;
`endif

  always_comb begin
    xs = {1'b0, px};
    ys = {1'b0, py};
    in_score = s0_v && xs >= SX0 && xs <= SX1 && ys >= SY0 && ys <= SY1;
    in_heart = s0_v && !in_score &&
               xs >= HX0 && xs <= HX1 && ys >= HY0 && ys <= HY1;
    off = in_score ? xs - SX0 : xs - HX0;
    row = in_score ? 6'(ys - SY0) : 6'(ys - HY0);
  end

  // Glyph slot by range compare; each slot is 30 columns wide.
  always_comb begin
    k   = 3'd7;
    col = 5'd0;
    unique case (1'b1)
      off < 11'd30: begin
        k = 3'd0; col = 5'(off);
      end
      off >= 11'd30 && off < 11'd60: begin
        k = 3'd1; col = 5'(off - 11'd30);
      end
      off >= 11'd60 && off < 11'd90: begin
        k = 3'd2; col = 5'(off - 11'd60);
      end
      off >= 11'd90 && off < 11'd120: begin
        k = 3'd3; col = 5'(off - 11'd90);
      end
      off >= 11'd120 && off < 11'd150: begin
        k = 3'd4; col = 5'(off - 11'd120);
      end
      default: ;
    endcase
    addr11 = {row, 5'b0} - {4'b0, row, 1'b0} + {6'b0, col};
  end

  always_comb begin
    unique case (k)
      3'd0:    dsel = sh_digits[15:12];
      3'd1:    dsel = sh_digits[11:8];
      3'd2:    dsel = sh_digits[7:4];
      default: dsel = sh_digits[3:0];
    endcase
`ifdef HUD_LEADING_ZERO_BLANK_EN
    unique case (k)
      3'd0:    lead = (sh_digits[15:12] == 4'd0);
      3'd1:    lead = (sh_digits[15:8] == 8'd0);
      3'd2:    lead = (sh_digits[15:4] == 12'd0);
      default: lead = 1'b0;
    endcase
    glyph_s = lead ? 4'd15 : dsel;
`else
    glyph_s = dsel;
`endif
    hh    = {1'b0, sh_health};
    two_i = {1'b0, k, 1'b0};
    if (hh >= two_i + 5'd2)      glyph_h = 4'd10;
    else if (hh == two_i + 5'd1) glyph_h = 4'd11;
    else                         glyph_h = 4'd15;
  end

  logic       v1;
  logic       v2;
  logic [4:0] d2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom.char_idx          <= 4'd15;
      rom.char_read_address <= 19'd0;
      v1                    <= 1'b0;
    end else if (in_score) begin
      rom.char_idx          <= glyph_s;
      rom.char_read_address <= 19'(addr11);
      v1                    <= 1'b1;
    end else if (in_heart) begin
      rom.char_idx          <= glyph_h;
      rom.char_read_address <= 19'(addr11);
      v1                    <= 1'b1;
    end else begin
      rom.char_idx          <= 4'd15;
      rom.char_read_address <= 19'd0;
      v1                    <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      d2        <= 5'd0;
      v2        <= 1'b0;
      hud_pixel <= 5'd0;
      hud_valid <= 1'b0;
    end else begin
      d2        <= rom.char_data_in;
      v2        <= v1;
      hud_pixel <= v2 ? d2 : 5'd0;
      hud_valid <= v2;
    end
  end

endmodule

// File: tb/tb_hud_char_sequencer.sv
// Scoreboard bench for hud_char_sequencer with a combinational glyph ROM model.
module tb_hud_char_sequencer;
  localparam int SX = 500;
  localparam int SY = 10;
  localparam int HX = 10;
  localparam int HY = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [13:0] score = 14'd0;
  logic [3:0]  health = 4'd0;
  logic [9:0]  draw_x = 10'd0;
  logic [9:0]  draw_y = 10'd300;
  logic [4:0]  hud_pixel;
  logic        hud_valid;
  logic        bcd_busy;

  hud_char_sequencer_if rif();

  function automatic logic [4:0] rom_fn(input logic [18:0] a,
                                        input logic [3:0] i);
    logic [18:0] t;
    t = a * 19'd7 + {15'b0, i} * 19'd3 + 19'd1;
    return t[4:0];
  endfunction

  assign rif.char_data_in = rom_fn(rif.char_read_address, rif.char_idx);

  hud_char_sequencer #(
    .SCORE_X(SX), .SCORE_Y(SY), .HEART_X(HX), .HEART_Y(HY)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .frame_start(frame_start),
    .score(score),
    .health(health),
    .DrawX(draw_x),
    .DrawY(draw_y),
    .rom(rif),
    .hud_pixel(hud_pixel),
    .hud_valid(hud_valid),
    .bcd_busy(bcd_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [18:0] addr;
    logic        valid;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic probe = 1'b0;
  logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0;
  int   passed = 0;
  int   total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) begin
    p1 <= probe;
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (p2) begin
      if (q1.size() == 0) check("q1_underflow", 1, 0);
      else begin
        e = q1.pop_front();
        check("char_idx", int'(rif.char_idx), int'(e.idx));
        check("char_addr", int'(rif.char_read_address), int'(e.addr));
      end
    end
    if (p4) begin
      if (q3.size() == 0) check("q3_underflow", 1, 0);
      else begin
        e = q3.pop_front();
        check("hud_valid", int'(hud_valid), int'(e.valid));
        check("hud_pixel", int'(hud_pixel),
              e.valid ? int'(rom_fn(e.addr, e.idx)) : 0);
      end
    end
  end

  task automatic do_probe(input int x, input int y, input int idx,
                          input int addr, input bit valid);
    exp_t e;
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    probe  = 1'b1;
    e.idx   = 4'(idx);
    e.addr  = 19'(addr);
    e.valid = valid;
    q1.push_back(e);
    q3.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    probe  = 1'b0;
    draw_x = 10'd0;
    draw_y = 10'd300;
    repeat (n) @(negedge clk);
  endtask

  task automatic probe_digits(input int a, input int b, input int c,
                              input int d);
    int e[4];
    e = '{a, b, c, d};
    for (int k = 0; k < 4; k++) do_probe(SX + 30 * k + 3, SY + 4, e[k], 123, 1);
    idle(6);
  endtask

  task automatic probe_hearts(input int a, input int b, input int c,
                              input int d, input int f);
    int e[5];
    e = '{a, b, c, d, f};
    for (int i = 0; i < 5; i++) do_probe(HX + 30 * i + 5, HY + 1, e[i], 35, 1);
    idle(6);
  endtask

  task automatic convert(input int s, input int h, input int extra_at,
                         output int n);
    int guard;
    @(negedge clk);
    score = 14'(s);
    health = 4'(h);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    guard = 0;
    while (bcd_busy && guard < 40) begin
      n++;
      guard++;
      frame_start = (n == extra_at);
      @(negedge clk);
    end
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_idx", int'(rif.char_idx), 15);
    check("rst_addr", int'(rif.char_read_address), 0);
    check("rst_pixel", int'(hud_pixel), 0);
    check("rst_valid", int'(hud_valid), 0);
    check("rst_busy", int'(bcd_busy), 0);
    rst = 1'b0;
    idle(4);

    probe_hearts(15, 15, 15, 15, 15);

    convert(1234, 7, 0, n);
    check("busy_1234", n, 15);
    do_probe(SX + 31, SY + 2, 2, 61, 1);
    idle(6);
    probe_digits(1, 2, 3, 4);
    probe_hearts(10, 10, 10, 11, 15);

    do_probe(SX, SY, 1, 0, 1);
    do_probe(SX + 119, SY + 44, 4, 1349, 1);
    do_probe(SX + 120, SY, 15, 0, 0);
    do_probe(SX - 1, SY, 15, 0, 0);
    do_probe(SX, SY + 45, 15, 0, 0);
    do_probe(HX + 149, HY + 44, 15, 1349, 1);
    do_probe(HX + 150, HY, 15, 0, 0);
    idle(6);

    score = 14'd9;
    health = 4'd2;
    repeat (5) @(negedge clk);
    probe_digits(1, 2, 3, 4);
    probe_hearts(10, 10, 10, 11, 15);

    convert(12000, 15, 5, n);
    check("busy_retrigger", n, 15);
    probe_digits(9, 9, 9, 9);
    probe_hearts(10, 10, 10, 10, 10);

    convert(5, 0, 0, n);
    check("busy_5", n, 15);
`ifdef HUD_LEADING_ZERO_BLANK_EN
    probe_digits(15, 15, 15, 5);
`else
    probe_digits(0, 0, 0, 5);
`endif
    probe_hearts(15, 15, 15, 15, 15);

    convert(0, 1, 0, n);
`ifdef HUD_LEADING_ZERO_BLANK_EN
    probe_digits(15, 15, 15, 0);
`else
    probe_digits(0, 0, 0, 0);
`endif
    probe_hearts(11, 15, 15, 15, 15);

    convert(42, 4, 0, n);
`ifdef HUD_LEADING_ZERO_BLANK_EN
    probe_digits(15, 15, 4, 2);
`else
    probe_digits(0, 0, 4, 2);
`endif

    @(negedge clk);
    score = 14'd1234;
    health = 4'd9;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (bcd_busy && n < 7) begin
      n++;
      @(negedge clk);
    end
    check("busy_before_reset", n, 7);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_reset", int'(bcd_busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_stays_idle", int'(bcd_busy), 0);
`ifdef HUD_LEADING_ZERO_BLANK_EN
    probe_digits(15, 15, 15, 0);
`else
    probe_digits(0, 0, 0, 0);
`endif
    probe_hearts(15, 15, 15, 15, 15);

    do_probe(0, 300, 15, 0, 0);
    idle(8);
    check("scoreboard_drained", q1.size() + q3.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
